input_act_stream_ctrl: RTL and testbench

Parametrised input-activation streamer. It buffers wide words written by the host into an internal FIFO, then slices each word into OUTPUT_WIDTH elements and sends them over a valid/ready stream to the MAC array. Compared with the previous controller it adds downstream backpressure, a programmable element count per feed, selectable slice order, an overflow flag and a done pulse. It sits between the memory-control register block and the conv/MLP datapath.

---
 rtl/input_act_stream_ctrl.sv | 162 ++++++++++++++++
 tb/tb_input_act_stream_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_act_stream_ctrl.sv
// Input-activation streamer: host words are queued in a FIFO, sliced into elements
// and sent downstream over valid/ready. Optional ELEM_COUNT port: INPUT_ACT_ELEM_CNT_EN.
module input_act_stream_ctrl #(
   parameter int INPUT_WIDTH  = 32,
   parameter int OUTPUT_WIDTH = 8,
   parameter int FIFO_DEPTH   = 64,
   parameter int LEN_WIDTH    = 16
) (
   input  logic                    CLK,
   input  logic                    RESETN,
   input  logic                    CLEAR,
   input  logic                    START,
   input  logic [LEN_WIDTH-1:0]    FEED_LEN,
   input  logic                    MSB_FIRST,
   input  logic                    WR_EN,
   input  logic [INPUT_WIDTH-1:0]  WR_DATA,
   output logic                    FIFO_EMPTY,
   output logic                    FIFO_FULL,
   output logic                    OVERFLOW,
   output logic [OUTPUT_WIDTH-1:0] DATA_OUT,
   output logic                    DATA_VALID,
   input  logic                    DATA_READY,
   output logic                    BUSY,
`ifdef INPUT_ACT_ELEM_CNT_EN
   output logic                    DONE,
   output logic [31:0]             ELEM_COUNT
`else
   output logic                    DONE
`endif
);

   localparam int S     = INPUT_WIDTH / OUTPUT_WIDTH;
   localparam int IDX_W = (S > 1) ? $clog2(S) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STREAM, ST_DONE} state_t;

   state_t                  state_q, state_d;
   logic [INPUT_WIDTH-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    fifo_empty_q, fifo_full_q, overflow_q;
   logic [LEN_WIDTH-1:0]    remaining_q;
   logic                    msb_first_q;
   logic [INPUT_WIDTH-1:0]  word_q;
   logic [IDX_W-1:0]        idx_q, sel;
   logic [OUTPUT_WIDTH-1:0] slices [S];
   logic                    handshake, last_slice, pop, wr_accept, overflow_set;

   assign handshake  = (state_q == ST_STREAM) && DATA_READY;
   assign last_slice = (idx_q == IDX_W'(S - 1));

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE:
            if (START) state_d = (FEED_LEN == '0) ? ST_DONE : ST_LOAD;
         ST_LOAD:
            if (!fifo_empty_q) begin
               pop     = 1'b1;
               state_d = ST_STREAM;
            end
         ST_STREAM:
            if (handshake) begin
               if (remaining_q == LEN_WIDTH'(1)) state_d = ST_DONE;
               else if (last_slice) begin
                  if (!fifo_empty_q) pop = 1'b1;
                  else               state_d = ST_LOAD;
               end
            end
         ST_DONE:
            state_d = ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
      if (CLEAR) begin
         state_d = ST_IDLE;
         pop     = 1'b0;
      end
   end

   // A full FIFO still accepts a write on the edge that pops its head.
   assign wr_accept    = WR_EN && !CLEAR && (!fifo_full_q || pop);
   assign overflow_set = WR_EN && fifo_full_q && !pop;
   assign count_d      = count_q + CNT_W'(wr_accept) - CNT_W'(pop);

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge CLK) begin
      if (!RESETN || CLEAR) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         fifo_empty_q <= 1'b1;
         fifo_full_q  <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         if (wr_accept)    wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
         if (pop)          rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
         if (overflow_set) overflow_q <= 1'b1;
         count_q      <= count_d;
         fifo_empty_q <= (count_d == '0);
         fifo_full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
      end
   end

   // NOTE: storage is not reset; the pointers and count alone define what is valid.
   always_ff @(posedge CLK) begin
      if (wr_accept) mem[wr_ptr_q] <= WR_DATA;
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         remaining_q <= '0;
         msb_first_q <= 1'b0;
         word_q      <= '0;
         idx_q       <= '0;
      end else if (!CLEAR) begin
         if (state_q == ST_IDLE && START) begin
            remaining_q <= FEED_LEN;
            msb_first_q <= MSB_FIRST;
         end
         if (handshake) remaining_q <= remaining_q - LEN_WIDTH'(1);
         if (pop) begin
            word_q <= mem[rd_ptr_q];
            idx_q  <= '0;
         end else if (handshake && !last_slice) begin
            idx_q <= idx_q + IDX_W'(1);
         end
      end
   end

   always_comb begin
      for (int k = 0; k < S; k++) slices[k] = word_q[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
   end

   assign sel        = msb_first_q ? (IDX_W'(S - 1) - idx_q) : idx_q;
   assign DATA_VALID = (state_q == ST_STREAM);
   assign DATA_OUT   = DATA_VALID ? slices[sel] : '0;
   assign BUSY       = (state_q != ST_IDLE);
   assign DONE       = (state_q == ST_DONE);
   assign FIFO_EMPTY = fifo_empty_q;
   assign FIFO_FULL  = fifo_full_q;
   assign OVERFLOW   = overflow_q;

`ifdef INPUT_ACT_ELEM_CNT_EN
   logic [31:0] elem_cnt_q;
   always_ff @(posedge CLK) begin
      if (!RESETN || CLEAR) elem_cnt_q <= '0;
      else if (handshake)   elem_cnt_q <= elem_cnt_q + 32'd1;
   end
   assign ELEM_COUNT = elem_cnt_q;
`endif

endmodule

// File: tb/tb_input_act_stream_ctrl.sv
// Directed bench for input_act_stream_ctrl: a per-cycle vector table plus
// hand-written sequences for LOAD stalls, overflow, CLEAR and reset mid-feed.
module tb_input_act_stream_ctrl;

   logic        CLK = 1'b0;
   logic        RESETN = 1'b0;
   logic        CLEAR = 1'b0;
   logic        START = 1'b0;
   logic [15:0] FEED_LEN = '0;
   logic        MSB_FIRST = 1'b0;
   logic        WR_EN = 1'b0;
   logic [31:0] WR_DATA = '0;
   logic        FIFO_EMPTY, FIFO_FULL, OVERFLOW;
   logic [7:0]  DATA_OUT;
   logic        DATA_VALID;
   logic        DATA_READY = 1'b0;
   logic        BUSY, DONE;
`ifdef INPUT_ACT_ELEM_CNT_EN
   logic [31:0] ELEM_COUNT;
`endif

   input_act_stream_ctrl dut (
      .CLK(CLK), .RESETN(RESETN), .CLEAR(CLEAR), .START(START),
      .FEED_LEN(FEED_LEN), .MSB_FIRST(MSB_FIRST), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
      .FIFO_EMPTY(FIFO_EMPTY), .FIFO_FULL(FIFO_FULL), .OVERFLOW(OVERFLOW),
      .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY),
      .BUSY(BUSY),
`ifdef INPUT_ACT_ELEM_CNT_EN
      .DONE(DONE), .ELEM_COUNT(ELEM_COUNT)
`else
      .DONE(DONE)
`endif
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Applies one cycle of inputs, then samples 1 time unit after the edge.
   task automatic drive(input logic st, input logic [15:0] len, input logic msb,
                        input logic wr, input logic [31:0] wd, input logic rdy,
                        input logic clr);
      START = st; FEED_LEN = len; MSB_FIRST = msb;
      WR_EN = wr; WR_DATA = wd; DATA_READY = rdy; CLEAR = clr;
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [5:0] flags();
      return {DATA_VALID, DONE, BUSY, FIFO_EMPTY, FIFO_FULL, OVERFLOW};
   endfunction

   // Expected flag patterns {valid, done, busy, empty, full, overflow}
   localparam logic [5:0] IDLE_E = 6'b000100, IDLE_N = 6'b000000;
   localparam logic [5:0] LOAD_N = 6'b001000, LOAD_E = 6'b001100;
   localparam logic [5:0] STR_N  = 6'b101000, STR_E  = 6'b101100;
   localparam logic [5:0] DONE_E = 6'b011100;

   typedef struct {
      logic        st;
      logic [15:0] len;
      logic        msb;
      logic        wr;
      logic [31:0] wd;
      logic        rdy;
      logic [5:0]  exp_flags;
      logic [7:0]  exp_data;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic st, input logic [15:0] len, input logic msb,
                      input logic wr, input logic [31:0] wd, input logic rdy,
                      input logic [5:0] ef, input logic [7:0] ed);
      vecs.push_back('{st, len, msb, wr, wd, rdy, ef, ed});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] a_exp [4];
      logic [7:0] b;

      // Test 1: two words, LSB first
      add(0, 0, 0, 1, 32'h44332211, 1, IDLE_N, 0);
      add(0, 0, 0, 1, 32'h88776655, 1, IDLE_N, 0);
      add(1, 8, 0, 0, 0, 1, LOAD_N, 0);
      add(0, 0, 0, 0, 0, 1, STR_N, 8'h11);
      add(0, 0, 0, 0, 0, 1, STR_N, 8'h22);
      add(0, 0, 0, 0, 0, 1, STR_N, 8'h33);
      add(0, 0, 0, 0, 0, 1, STR_N, 8'h44);
      add(0, 0, 0, 0, 0, 1, STR_E, 8'h55);
      add(0, 0, 0, 0, 0, 1, STR_E, 8'h66);
      add(0, 0, 0, 0, 0, 1, STR_E, 8'h77);
      add(0, 0, 0, 0, 0, 1, STR_E, 8'h88);
      add(0, 0, 0, 0, 0, 1, DONE_E, 0);
      add(0, 0, 0, 0, 0, 1, IDLE_E, 0);
      // Test 2: same data, MSB first
      add(0, 0, 0, 1, 32'h44332211, 1, IDLE_N, 0);
      add(0, 0, 0, 1, 32'h88776655, 1, IDLE_N, 0);
      add(1, 8, 1, 0, 0, 1, LOAD_N, 0);
      add(0, 0, 0, 0, 0, 1, STR_N, 8'h44);
      add(0, 0, 0, 0, 0, 1, STR_N, 8'h33);
      add(0, 0, 0, 0, 0, 1, STR_N, 8'h22);
      add(0, 0, 0, 0, 0, 1, STR_N, 8'h11);
      add(0, 0, 0, 0, 0, 1, STR_E, 8'h88);
      add(0, 0, 0, 0, 0, 1, STR_E, 8'h77);
      add(0, 0, 0, 0, 0, 1, STR_E, 8'h66);
      add(0, 0, 0, 0, 0, 1, STR_E, 8'h55);
      add(0, 0, 0, 0, 0, 1, DONE_E, 0);
      add(0, 0, 0, 0, 0, 1, IDLE_E, 0);
      // Test 3: partial word, then zero-length feed
      add(0, 0, 0, 1, 32'hDDCCBBAA, 1, IDLE_N, 0);
      add(1, 3, 0, 0, 0, 1, LOAD_N, 0);
      add(0, 0, 0, 0, 0, 1, STR_E, 8'hAA);
      add(0, 0, 0, 0, 0, 1, STR_E, 8'hBB);
      add(0, 0, 0, 0, 0, 1, STR_E, 8'hCC);
      add(0, 0, 0, 0, 0, 1, DONE_E, 0);
      add(0, 0, 0, 0, 0, 1, IDLE_E, 0);
      add(1, 0, 0, 0, 0, 1, DONE_E, 0);
      add(0, 0, 0, 0, 0, 1, IDLE_E, 0);
      add(0, 0, 0, 0, 0, 1, IDLE_E, 0);
      // Test 4: backpressure 1,0,0,1
      add(0, 0, 0, 1, 32'h04030201, 1, IDLE_N, 0);
      add(1, 4, 0, 0, 0, 1, LOAD_N, 0);
      add(0, 0, 0, 0, 0, 1, STR_E, 8'h01);
      add(0, 0, 0, 0, 0, 1, STR_E, 8'h02);
      add(0, 0, 0, 0, 0, 0, STR_E, 8'h02);
      add(0, 0, 0, 0, 0, 0, STR_E, 8'h02);
      add(0, 0, 0, 0, 0, 1, STR_E, 8'h03);
      add(0, 0, 0, 0, 0, 1, STR_E, 8'h04);
      add(0, 0, 0, 0, 0, 1, DONE_E, 0);
      add(0, 0, 0, 0, 0, 1, IDLE_E, 0);

      // Reset state
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      check("reset flags", 32'(flags()), 32'(IDLE_E));
      check("reset data", 32'(DATA_OUT), 32'h0);
      RESETN = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].st, vecs[i].len, vecs[i].msb, vecs[i].wr, vecs[i].wd, vecs[i].rdy, 1'b0);
         check($sformatf("vec%0d flags", i), 32'(flags()), 32'(vecs[i].exp_flags));
         if (vecs[i].exp_flags[5])
            check($sformatf("vec%0d data", i), 32'(DATA_OUT), 32'(vecs[i].exp_data));
      end
`ifdef INPUT_ACT_ELEM_CNT_EN
      check("elem_count total", ELEM_COUNT, 32'd23);
`endif

      // Test 5: feed outruns the FIFO and waits in LOAD
      a_exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      drive(0, 0, 0, 1, 32'hD4C3B2A1, 1, 0);
      drive(1, 6, 0, 0, 0, 1, 0);
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 0, 0, 1, 0);
         check($sformatf("t5 elem%0d", k), 32'(DATA_OUT), 32'(a_exp[k]));
         check($sformatf("t5 valid%0d", k), 32'(DATA_VALID), 32'd1);
      end
      drive(0, 0, 0, 0, 0, 1, 0);
      check("t5 load wait 1", 32'(flags()), 32'(LOAD_E));
      drive(0, 0, 0, 0, 0, 1, 0);
      check("t5 load wait 2", 32'(flags()), 32'(LOAD_E));
      drive(0, 0, 0, 1, 32'h0000BEEF, 1, 0);
      check("t5 after write", 32'(flags()), 32'(LOAD_N));
      drive(0, 0, 0, 0, 0, 1, 0);
      check("t5 EF", 32'({flags(), DATA_OUT}), 32'({STR_E, 8'hEF}));
      drive(0, 0, 0, 0, 0, 1, 0);
      check("t5 BE", 32'({flags(), DATA_OUT}), 32'({STR_E, 8'hBE}));
      drive(0, 0, 0, 0, 0, 1, 0);
      check("t5 done", 32'(flags()), 32'(DONE_E));
      drive(0, 0, 0, 0, 0, 1, 0);
      check("t5 idle", 32'(flags()), 32'(IDLE_E));

      // Test 6: fill, overflow, then CLEAR mid-feed
      for (int i = 0; i < 64; i++) begin
         b = 8'(4 * i);
         drive(0, 0, 0, 1, {b + 8'd3, b + 8'd2, b + 8'd1, b}, 1, 0);
      end
      check("t6 full", 32'(flags()), 32'b000010);
      drive(0, 0, 0, 1, 32'hDEADBEEF, 1, 0);
      check("t6 overflow", 32'(flags()), 32'b000011);
      drive(1, 10, 0, 0, 0, 1, 0);
      check("t6 load", 32'(flags()), 32'b001011);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 0, 0, 1, 0);
         check($sformatf("t6 elem%0d", k), 32'(DATA_OUT), 32'(k));
      end
      check("t6 not full after pop", 32'(FIFO_FULL), 32'd0);
      drive(0, 0, 0, 1, 32'h12345678, 1, 1);
      check("t6 clear", 32'(flags()), 32'(IDLE_E));
      drive(0, 0, 0, 0, 0, 1, 0);
      check("t6 after clear", 32'(flags()), 32'(IDLE_E));
`ifdef INPUT_ACT_ELEM_CNT_EN
      check("elem_count cleared", ELEM_COUNT, 32'd0);
`endif

      // Reset mid-feed: no DONE pulse, FIFO empty
      drive(0, 0, 0, 1, 32'h11111111, 1, 0);
      drive(1, 4, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      check("rst streaming", 32'({flags(), DATA_OUT}), 32'({STR_E, 8'h11}));
      RESETN = 1'b0;
      drive(0, 0, 0, 0, 0, 1, 0);
      check("rst mid-feed", 32'({flags(), DATA_OUT}), 32'({IDLE_E, 8'h00}));
      RESETN = 1'b1;
      drive(0, 0, 0, 0, 0, 1, 0);
      check("rst no done", 32'(flags()), 32'(IDLE_E));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
